// File: rtl/song_sequencer_pkg.sv
// Shared constants for the song sequencer: mode codes, ROM word layout, FSM states.
// Optional build macro used by the sequencer: LOOP_EN (replay from index 0 on end marker).
package song_sequencer_pkg;

  localparam logic [2:0] MODE_AUTO = 3'b011;
  localparam logic [2:0] MODE_MAN  = 3'b001;
  localparam logic [2:0] MODE_LRN  = 3'b111;

  localparam logic [7:0] END_MARKER = 8'h00;

  // ROM word: {note[7:3], dur[2:0]}
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 3;
  localparam int DUR_MSB  = 2;
  localparam int DUR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_PLAY    = 3'd3,
    ST_GAP     = 3'd4,
    ST_WAITKEY = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Counter must hold the longest note (7 beats) as well as the inter-note gap.
  function automatic int cnt_width(input int beat, input int gap);
    int hi;
    hi = (7 * beat > gap) ? 7 * beat : gap;
    return $clog2(hi + 1);
  endfunction

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// Loadable down-counter shared by note and gap timing; expire fires on the last enabled count.
module song_sequencer_beat_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM in auto (timed) or learning (key-gated) mode.
// Build macro LOOP_EN: end marker restarts the song at index 0 instead of parking in DONE.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             pause,
  input  logic [1:0]       song_num,
  input  logic             key_valid,
  input  logic [4:0]       key_note,
  output logic [IDX_W+1:0] rom_addr,
  input  logic [7:0]       rom_data,
  output logic [4:0]       note_out,
  output logic [4:0]       expect_note,
  output logic             hit,
  output logic             song_done,
  output state_t           dbg_state
);

  localparam int CNT_W = cnt_width(BEAT_TICKS, GAP_TICKS);
  localparam logic [CNT_W-1:0] BEAT_C = CNT_W'(BEAT_TICKS);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TICKS);

  state_t           state_q, state_d;
  logic [1:0]       song_q, song_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W+1:0] rom_addr_q, rom_addr_d;
  logic [4:0]       note_q, note_d;
  logic [4:0]       note_out_q, note_out_d;
  logic [4:0]       expect_q, expect_d;
  logic             hit_q, hit_d;
  logic             done_q, done_d;

  logic             tmr_load, tmr_en, tmr_expire;
  logic [CNT_W-1:0] tmr_val;
  logic             go_next;

  logic             mode_auto, mode_lrn, run_mode;
  logic [4:0]       rom_note;
  logic [2:0]       rom_dur, dur_eff;

  assign mode_auto = (mode == MODE_AUTO);
  assign mode_lrn  = (mode == MODE_LRN);
  assign run_mode  = mode_auto || mode_lrn;
  assign rom_note  = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
  assign dur_eff   = (rom_dur == 3'd0) ? 3'd1 : rom_dur;
  assign tmr_en    = !(mode_auto && pause);

  song_sequencer_beat_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    note_d     = note_q;
    note_out_d = note_out_q;
    expect_d   = expect_q;
    hit_d      = 1'b0;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    go_next    = 1'b0;

    if (state_q != ST_IDLE && !run_mode) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      rom_addr_d = '0;
      note_out_d = '0;
      expect_d   = '0;
    end else if (state_q != ST_IDLE && song_num != song_q) begin
      // A new song wins over any timer expiry or key hit in the same cycle.
      state_d    = ST_FETCH;
      song_d     = song_num;
      idx_d      = '0;
      rom_addr_d = {song_num, {IDX_W{1'b0}}};
      note_out_d = '0;
      expect_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((mode_auto && !pause) || mode_lrn) begin
            state_d    = ST_FETCH;
            song_d     = song_num;
            idx_d      = '0;
            rom_addr_d = {song_num, {IDX_W{1'b0}}};
          end
        end
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          if (rom_data == END_MARKER) begin
            done_d = 1'b1;
`ifdef LOOP_EN
            state_d    = ST_FETCH;
            idx_d      = '0;
            rom_addr_d = {song_q, {IDX_W{1'b0}}};
`else
            state_d = ST_DONE;
`endif
          end else begin
            note_d = rom_note;
            if (mode_lrn) begin
              if (rom_note == 5'd0) begin
                go_next = 1'b1;
              end else begin
                state_d  = ST_WAITKEY;
                expect_d = rom_note;
              end
            end else begin
              state_d    = ST_PLAY;
              note_out_d = rom_note;
              tmr_load   = 1'b1;
              tmr_val    = CNT_W'(dur_eff) * BEAT_C;
            end
          end
        end
        ST_PLAY: begin
          if (tmr_expire) begin
            state_d    = ST_GAP;
            note_out_d = '0;
            tmr_load   = 1'b1;
            tmr_val    = GAP_C;
          end
        end
        ST_GAP: if (tmr_expire) go_next = 1'b1;
        ST_WAITKEY: begin
          if (key_valid && key_note == expect_q) begin
            hit_d      = 1'b1;
            state_d    = ST_PLAY;
            note_out_d = note_q;
            expect_d   = '0;
            tmr_load   = 1'b1;
            tmr_val    = BEAT_C;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase

      // Step to the next word, or stop if the index space is exhausted without a marker.
      if (go_next) begin
        if (idx_q == {IDX_W{1'b1}}) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_FETCH;
          idx_d      = idx_q + IDX_W'(1);
          rom_addr_d = {song_q, idx_q + IDX_W'(1)};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      song_q     <= '0;
      idx_q      <= '0;
      rom_addr_q <= '0;
      note_q     <= '0;
      note_out_q <= '0;
      expect_q   <= '0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      note_q     <= note_d;
      note_out_q <= note_out_d;
      expect_q   <= expect_d;
      hit_q      <= hit_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign note_out    = (mode_auto && pause) ? 5'd0 : note_out_q;
  assign expect_note = expect_q;
  assign hit         = hit_q;
  assign song_done   = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a small synchronous ROM model and hand-derived traces.
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  localparam int IDX_W = 8;
  localparam int AW    = IDX_W + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    mode;
  logic          pause;
  logic [1:0]    song_num;
  logic          key_valid;
  logic [4:0]    key_note;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [4:0]    note_out;
  logic [4:0]    expect_note;
  logic          hit;
  logic          song_done;
  state_t        dbg_state;

  logic [7:0] rom [0:(1<<AW)-1];
  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  song_sequencer #(.BEAT_TICKS(4), .GAP_TICKS(2), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .pause       (pause),
    .song_num    (song_num),
    .key_valid   (key_valid),
    .key_note    (key_note),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note_out    (note_out),
    .expect_note (expect_note),
    .hit         (hit),
    .song_done   (song_done),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_n(input int n, input logic [5:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  // Each entry is {song_done, note_out} for one cycle; pause toggles at the given cycles.
  task automatic run_trace(input string tag, input int pon, input int poff);
    int k;
    logic [5:0] e;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k++;
      tick();
      if (k == pon)  pause = 1'b1;
      if (k == poff) pause = 1'b0;
      smp();
      chk($sformatf("%s[%0d]", tag, k), {26'd0, song_done, note_out}, {26'd0, e});
    end
  endtask

  task automatic go_idle(input string tag);
    tick();
    mode = MODE_MAN;
    tick();
    smp();
    chk({tag, "_state"}, dbg_state, ST_IDLE);
    chk({tag, "_note"}, note_out, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'h00;
    rom[10'h000] = 8'h2A;  // note 5, dur 2
    rom[10'h001] = 8'h39;  // note 7, dur 1
    rom[10'h100] = 8'h29;  // note 5, dur 1
    rom[10'h101] = 8'h49;  // note 9, dur 1
    rom[10'h200] = 8'h1B;  // note 3, dur 3

    rst_n = 1'b0; mode = MODE_MAN; pause = 1'b0; song_num = 2'd0;
    key_valid = 1'b0; key_note = 5'd0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_note", note_out, 5'd0);
    chk("rst_expect", expect_note, 5'd0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_done", song_done, 1'b0);
    chk("rst_addr", rom_addr, 10'h000);
    tick();
    rst_n = 1'b1;

    // Auto playback of song 0
    tick();
    mode = MODE_AUTO;
    push_n(2, 6'h00); push_n(8, 6'h05); push_n(4, 6'h00); push_n(4, 6'h07);
    push_n(4, 6'h00); push_n(1, 6'h20);
`ifdef LOOP_EN
    push_n(1, 6'h00); push_n(1, 6'h05);
`else
    push_n(2, 6'h00);
`endif
    run_trace("auto", 0, 0);
`ifdef LOOP_EN
    chk("loop_state", dbg_state, ST_PLAY);
    chk("loop_addr", rom_addr, 10'h000);
`else
    chk("done_state", dbg_state, ST_DONE);
    chk("done_addr", rom_addr, 10'h002);
    repeat (3) tick();
    smp();
    chk("done_hold", dbg_state, ST_DONE);
`endif
    go_idle("man1");

    // Pause mid-note: 3 cycles of note, 10 paused, 5 remaining
    tick();
    mode = MODE_AUTO;
    push_n(2, 6'h00); push_n(3, 6'h05); push_n(10, 6'h00); push_n(5, 6'h05);
    push_n(2, 6'h00);
    run_trace("pause", 6, 16);
    go_idle("man2");

    // Learning mode on song 1
    tick();
    mode = MODE_LRN;
    song_num = 2'd1;
    smp();
    tick(); smp();
    chk("lrn_fetch", dbg_state, ST_FETCH);
    chk("lrn_addr0", rom_addr, 10'h100);
    tick(); smp();
    tick(); smp();
    chk("lrn_wait", dbg_state, ST_WAITKEY);
    chk("lrn_expect", expect_note, 5'd5);
    chk("lrn_silent", note_out, 5'd0);
    tick(); key_valid = 1'b1; key_note = 5'd3; smp();
    tick(); key_valid = 1'b0; smp();
    chk("wrong_hit", hit, 1'b0);
    chk("wrong_state", dbg_state, ST_WAITKEY);
    chk("wrong_expect", expect_note, 5'd5);
    tick(); key_valid = 1'b1; key_note = 5'd5; smp();
    tick(); key_valid = 1'b0; pause = 1'b1; smp();
    chk("hit_pulse", hit, 1'b1);
    chk("hit_note", note_out, 5'd5);
    chk("hit_expect", expect_note, 5'd0);
    chk("hit_nodone", song_done, 1'b0);
    tick(); smp();
    chk("hit_clear", hit, 1'b0);
    chk("lrn_note2", note_out, 5'd5);
    tick(); smp();
    tick(); smp();
    chk("lrn_note4", note_out, 5'd5);
    tick(); pause = 1'b0; smp();
    chk("lrn_gap", dbg_state, ST_GAP);
    chk("lrn_gap_note", note_out, 5'd0);
    tick(); smp();
    tick(); smp();
    chk("lrn_next_fetch", dbg_state, ST_FETCH);
    chk("lrn_addr1", rom_addr, 10'h101);
    tick(); smp();
    tick(); smp();
    chk("lrn_expect2", expect_note, 5'd9);
    tick(); song_num = 2'd0;
    go_idle("man3");

    // Song change during PLAY
    tick();
    mode = MODE_AUTO;
    tick(); tick(); tick();
    smp();
    chk("sw_play", note_out, 5'd5);
    tick(); song_num = 2'd2; smp();
    tick(); smp();
    chk("sw_state", dbg_state, ST_FETCH);
    chk("sw_addr", rom_addr, 10'h200);
    chk("sw_note", note_out, 5'd0);
    tick(); smp();
    tick(); smp();
    chk("sw_newnote", note_out, 5'd3);

    // Asynchronous reset between clock edges
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_note", note_out, 5'd0);
    chk("arst_state", dbg_state, ST_IDLE);
    chk("arst_addr", rom_addr, 10'h000);
    mode = MODE_MAN;
    tick();
    rst_n = 1'b1;
    tick(); smp();
    chk("arst_idle", dbg_state, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
